// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the stream round-robin arbiter family.
package stream_rr_arbiter_pkg;

`ifndef STREAM_WORD_WIDTH
`define STREAM_WORD_WIDTH 64
`endif

    localparam int unsigned BeatWidth = `STREAM_WORD_WIDTH;

    typedef struct packed {
        logic [BeatWidth-1:0] payload;
        logic                 last;
    } stream_beat_t;

    // Index width with a floor of one bit so a single-entry table still has a port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Requester-side and downstream-side stream signals of stream_rr_arbiter.
interface stream_rr_arbiter_if #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned WordWidth = 64
);
    localparam int unsigned IdxW = stream_rr_arbiter_pkg::idx_w(NumReq);

    logic [NumReq-1:0]           req_vld_i;
    logic [NumReq*WordWidth-1:0] req_payload_i;
    logic [NumReq-1:0]           req_last_i;
    logic [NumReq-1:0]           req_rdy_o;
    logic                        out_vld_o;
    logic [WordWidth-1:0]        out_payload_o;
    logic                        out_last_o;
    logic [IdxW-1:0]             out_src_o;
    logic                        out_rdy_i;

    modport slave (
        input  req_vld_i, req_payload_i, req_last_i, out_rdy_i,
        output req_rdy_o, out_vld_o, out_payload_o, out_last_o, out_src_o
    );

    modport master (
        output req_vld_i, req_payload_i, req_last_i, out_rdy_i,
        input  req_rdy_o, out_vld_o, out_payload_o, out_last_o, out_src_o
    );
endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational find-first-set starting at a pointer, wrapping modulo NumReq.
module rr_pick
    import stream_rr_arbiter_pkg::*;
#(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = idx_w(NumReq)
) (
    input  logic [NumReq-1:0] vld_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    int cand;

    // Scan offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            cand = (int'(ptr_i) + i) % int'(NumReq);
            if (vld_i[cand]) begin
                idx_o = IdxW'(cand);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-aware N-to-1 round-robin stream arbiter with a one-entry registered output stage.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned WordWidth = 64
) (
    input logic              clk,
    input logic              rst,
    input logic              flush_i,
    stream_rr_arbiter_if.slave bus
);

    localparam int unsigned IdxW = idx_w(NumReq);

    logic                 out_vld_q, out_vld_d;
    logic [WordWidth-1:0] out_payload_q, out_payload_d;
    logic                 out_last_q, out_last_d;
    logic [IdxW-1:0]      out_src_q, out_src_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 locked_q, locked_d;
    logic [IdxW-1:0]      lock_idx_q, lock_idx_d;

    logic [IdxW-1:0]      pick_idx;
    logic                 pick_any;
    logic [IdxW-1:0]      gnt;
    logic                 gnt_vld;
    logic                 load;
    logic                 accept;
    logic [WordWidth-1:0] gnt_payload;
    logic                 gnt_last;
    logic [NumReq-1:0]    req_rdy;

    rr_pick #(
        .NumReq(NumReq)
    ) u_rr_pick (
        .vld_i(bus.req_vld_i),
        .ptr_i(rr_ptr_q),
        .idx_o(pick_idx),
        .any_o(pick_any)
    );

    always_comb begin
        load        = (~out_vld_q | bus.out_rdy_i) & ~flush_i;
        gnt         = locked_q ? lock_idx_q : pick_idx;
        gnt_vld     = locked_q ? bus.req_vld_i[lock_idx_q] : pick_any;
        accept      = load & gnt_vld;
        gnt_payload = bus.req_payload_i[int'(gnt)*WordWidth +: WordWidth];
        gnt_last    = bus.req_last_i[gnt];
        req_rdy     = '0;
        for (int r = 0; r < int'(NumReq); r++) begin
            req_rdy[r] = accept & (gnt == IdxW'(r));
        end
    end

    // Flush wins over accept and drain; the pointer only advances at packet boundaries.
    always_comb begin
        out_vld_d     = out_vld_q;
        out_payload_d = out_payload_q;
        out_last_d    = out_last_q;
        out_src_d     = out_src_q;
        rr_ptr_d      = rr_ptr_q;
        locked_d      = locked_q;
        lock_idx_d    = lock_idx_q;
        if (flush_i) begin
            out_vld_d = 1'b0;
            locked_d  = 1'b0;
        end else if (accept) begin
            out_vld_d     = 1'b1;
            out_payload_d = gnt_payload;
            out_last_d    = gnt_last;
            out_src_d     = gnt;
            if (gnt_last) begin
                locked_d = 1'b0;
                rr_ptr_d = (gnt == IdxW'(NumReq - 1)) ? '0 : gnt + IdxW'(1);
            end else begin
                locked_d   = 1'b1;
                lock_idx_d = gnt;
            end
        end else if (bus.out_rdy_i & out_vld_q) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q     <= 1'b0;
            out_payload_q <= '0;
            out_last_q    <= 1'b0;
            out_src_q     <= '0;
            rr_ptr_q      <= '0;
            locked_q      <= 1'b0;
            lock_idx_q    <= '0;
        end else begin
            out_vld_q     <= out_vld_d;
            out_payload_q <= out_payload_d;
            out_last_q    <= out_last_d;
            out_src_q     <= out_src_d;
            rr_ptr_q      <= rr_ptr_d;
            locked_q      <= locked_d;
            lock_idx_q    <= lock_idx_d;
        end
    end

    assign bus.req_rdy_o     = req_rdy;
    assign bus.out_vld_o     = out_vld_q;
    assign bus.out_payload_o = out_payload_q;
    assign bus.out_last_o    = out_last_q;
    assign bus.out_src_o     = out_src_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed plus randomized bench for stream_rr_arbiter against a rule-level reference model.
module tb_stream_rr_arbiter;

    localparam int NumReq = 4;
    localparam int W      = 64;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   vecs  = 0;
    int   fails = 0;

    // Reference model: arbitration state expressed as the plain rules of the block.
    int          m_ptr;
    int          m_lock;
    bit          m_locked;
    bit          m_vld;
    logic [W-1:0] m_pay;
    logic        m_last;
    logic [1:0]  m_src;

    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.NumReq(NumReq), .WordWidth(W)) bus ();

    stream_rr_arbiter #(
        .NumReq(NumReq),
        .WordWidth(W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_lock   = 0;
        m_locked = 0;
        m_vld    = 0;
        m_pay    = '0;
        m_last   = 1'b0;
        m_src    = 2'd0;
    endtask

    function automatic int model_gnt(input logic [3:0] vld, output bit gv);
        gv = 0;
        if (m_locked) begin
            gv = vld[m_lock];
            return m_lock;
        end
        for (int k = 0; k < NumReq; k++) begin
            if (vld[(m_ptr + k) % NumReq]) begin
                gv = 1;
                return (m_ptr + k) % NumReq;
            end
        end
        return 0;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, "_vld"}, 64'(bus.out_vld_o), 64'(m_vld));
        chk({tag, "_pay"}, bus.out_payload_o, m_pay);
        chk({tag, "_last"}, 64'(bus.out_last_o), 64'(m_last));
        chk({tag, "_src"}, 64'(bus.out_src_o), 64'(m_src));
    endtask

    // One cycle: drive at negedge, check comb and registered outputs, then advance the model.
    task automatic step(input logic [3:0] vld, input logic [3:0] last, input logic ordy,
                        input logic fl);
        logic [NumReq*W-1:0] pay;
        int  g;
        bit  gv;
        bit  acc;
        @(negedge clk);
        for (int i = 0; i < NumReq; i++) pay[i*W +: W] = {$urandom, $urandom};
        bus.req_vld_i     = vld;
        bus.req_last_i    = last;
        bus.req_payload_i = pay;
        bus.out_rdy_i     = ordy;
        flush             = fl;
        #1;
        g   = model_gnt(vld, gv);
        acc = gv && (!m_vld || ordy) && !fl;
        chk("req_rdy", 64'(bus.req_rdy_o), acc ? 64'(4'b0001 << g) : 64'd0);
        check_outs("out");
        @(posedge clk);
        if (fl) begin
            m_vld    = 0;
            m_locked = 0;
        end else if (acc) begin
            m_vld  = 1;
            m_pay  = pay[g*W +: W];
            m_last = last[g];
            m_src  = 2'(g);
            if (last[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % NumReq;
            end else begin
                m_locked = 1;
                m_lock   = g;
            end
        end else if (ordy && m_vld) begin
            m_vld = 0;
        end
    endtask

    // Look at registered outputs shortly after the edge that a step ended on.
    task automatic peek_src(input string tag, input logic [1:0] exp);
        #2;
        chk(tag, 64'(bus.out_src_o), 64'(exp));
    endtask

    initial begin
        rst               = 1'b0;
        flush             = 1'b0;
        bus.req_vld_i     = '0;
        bus.req_last_i    = '0;
        bus.req_payload_i = '0;
        bus.out_rdy_i     = 1'b0;
        model_reset();
        #2 rst = 1'b1;
        #1;
        check_outs("rst0");
        chk("rst0_rdy", 64'(bus.req_rdy_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Mid-packet asynchronous reset with a full stage.
        step(4'b0100, 4'b0000, 1'b0, 1'b0);
        peek_src("pre_rst_src", 2'd2);
        @(negedge clk);
        #2;
        bus.req_vld_i = '0;
        rst           = 1'b1;
        #1;
        model_reset();
        check_outs("rst1");
        chk("rst1_rdy", 64'(bus.req_rdy_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-beat packets from everyone rotate 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b1, 1'b0);
            peek_src("rot_src", 2'(k % 4));
        end

        // r1 three-beat packet while r2 waits; pointer is at 1.
        step(4'b0110, 4'b0000, 1'b1, 1'b0);
        peek_src("pkt_b1", 2'd1);
        step(4'b0110, 4'b0000, 1'b1, 1'b0);
        peek_src("pkt_b2", 2'd1);
        step(4'b0110, 4'b0010, 1'b1, 1'b0);
        peek_src("pkt_b3", 2'd1);
        step(4'b0100, 4'b0100, 1'b1, 1'b0);
        peek_src("pkt_next", 2'd2);

        // Only r2 valid with pointer at 3: wrap grants r2 and leaves the pointer at 3.
        step(4'b0100, 4'b0100, 1'b1, 1'b0);
        peek_src("wrap_r2", 2'd2);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        peek_src("wrap_ptr3", 2'd3);

        // Backpressure holds the stage, release resumes one beat per cycle.
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 4'b1111, 1'b0, 1'b0);
            peek_src("stall_src", 2'd3);
        end
        for (int k = 0; k < 4; k++) begin
            step(4'b1111, 4'b1111, 1'b1, 1'b0);
            peek_src("resume_src", 2'(k));
        end

        // Flush during an r3 packet clears the lock; r0 is next with pointer 0.
        step(4'b1000, 4'b0000, 1'b1, 1'b0);
        peek_src("flush_pre", 2'd3);
        step(4'b1000, 4'b0000, 1'b1, 1'b1);
        #2;
        chk("flush_vld", 64'(bus.out_vld_o), 64'd0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        peek_src("flush_post", 2'd0);

        // Randomized traffic, backpressure and occasional flush.
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
